hilo_mult_unit: RTL and testbench
=================================

Name: hilo_mult_unit

Overview:
- Execute-stage consumer of the ALU control decoder's ALUCtl/HiLoWrite outputs for all HI/LO-class instructions: mult, multu, madd, msub, mul, mthi, mtlo, mfhi, mflo.
- Holds the architectural HI/LO registers and runs an iterative signed/unsigned 32x32 multiplier.
- Drives a pipeline stall when an instruction depends on an in-flight multiply.

Parameters:
- RADIX_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4.
- N (derived, not overridable), 32/RADIX_BITS, multiply iteration count.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- InValid  in  1  EX stage holds a live (not flushed) instruction.
- ALUCtl  in  5  operation code from the ALU control decoder.
- HiLoWrite  in  1  decoder flag: op writes HI/LO or uses the multiplier.
- A  in  32  rs operand.
- B  in  32  rt operand.
- HiOut  out  32  current HI register.
- LoOut  out  32  current LO register.
- MulResult  out  32  low 32 bits of the mul product, registered.
- ResultValid  out  1  MulResult valid (DONE state).
- Busy  out  1  multiplier in flight.
- Stall  out  1  freeze IF/ID/EX; combinational.

Behaviour:
- Op codes consumed:
  - Require HiLoWrite=1: mult 00101, multu 01110, madd 01100, msub 01101, mul 11000, mthi 10001, mtlo 10011. multu moves to 01110 and the decoder changes with this block.
  - Require HiLoWrite=0: mfhi 10000, mflo 10010.
  - Any other code: ignored, never stalls.
- Reset: HI=LO=0, MulResult=0, ResultValid=0, Busy=0, state IDLE, counter 0. Reset mid-multiply aborts it; no HI/LO commit.
- States: IDLE, MUL, DONE.
- IDLE, InValid=1:
  - mult/multu/madd/msub: latch operands, op, sign; counter=N; go to MUL. Stall=0; the instruction retires.
  - mul: as above, plus set the blocking flag. Stall=1 this cycle.
  - mthi/mtlo: write A into HI/LO on this edge. Visible next cycle.
  - mfhi/mflo: HiOut/LoOut already hold the values. Stall=0.
- MUL:
  - Busy=1.
  - Each cycle retires RADIX_BITS of |B| against |A| (shift-add, 64-bit partial product); counter decrements.
  - On the edge where the counter goes 1->0:
    - mult/multu: {HI,LO} = product.
    - madd: {HI,LO} = {HI,LO} + product.
    - msub: {HI,LO} = {HI,LO} - product.
    - Non-blocking ops go to IDLE.
    - mul: HI/LO unchanged; MulResult = product[31:0]; go to DONE.
  - Signed ops (mult, madd, msub, mul) take magnitudes and negate the 64-bit product when sign(A) xor sign(B). multu uses raw operands.
  - madd/msub accumulate with 64-bit wrap; no overflow flag.
- Stall in MUL: Stall=1 whenever InValid=1 and the code is any consumed op (HiLoWrite-class or mfhi/mflo), including the blocked mul itself. Non-HI/LO instructions do not stall.
- DONE:
  - One cycle. ResultValid=1, Stall=0, no new op accepted (the EX instruction is the completed mul).
  - Then IDLE; ResultValid=0 and MulResult holds its value.
- Latency:
  - Non-blocking ops: HI/LO updated N cycles after the accept edge.
  - mul: Stall high for N+1 cycles, ResultValid on cycle N+1 after accept.
  - mfhi after mult: stalls until the commit, then reads the new value the cycle after.
- InValid=0: no acceptance, no stall; an in-flight multiply continues.
- Simultaneous mthi/mtlo while MUL: stalled, not written; executes in IDLE after the commit, so its write wins over the multiply result.

Test Plan:
- Reset, then mult A=0xFFFFFFFF B=0x00000002, RADIX_BITS=1 -> Busy 32 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; Stall never high.
- multu A=0xFFFFFFFF B=0x00000002 -> HI=0x00000001 LO=0xFFFFFFFE after 32 cycles.
- mthi 0, mtlo 5, then madd A=3 B=4 -> LO=0x00000011 HI=0. Next, msub A=1 B=0x12 from HI=0 LO=0x11 -> HI=LO=0xFFFFFFFF.
- mul A=7 B=0xFFFFFFFD -> Stall high 33 cycles, ResultValid 1 cycle, MulResult=0xFFFFFFEB; HI/LO unchanged.
- mult 2x3 immediately followed by mfhi/mflo -> mflo stalls until the commit, then LoOut=0x00000006. Repeat at RADIX_BITS=4 -> 8-cycle busy.
- Assert Rst at iteration 10 of a mult -> HI=LO=0, Busy=0, Stall=0 immediately (async), IDLE; a new mult after release completes normally.

Source files
------------

// File: rtl/hilo_mult_unit.sv
// HI/LO register file plus iterative 32x32 signed/unsigned multiplier for the EX stage.
// Retires RADIX_BITS multiplier bits per cycle; stalls dependent HI/LO instructions while in flight.
module hilo_mult_unit #(
  parameter int RADIX_BITS = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        InValid,
  input  logic [4:0]  ALUCtl,
  input  logic        HiLoWrite,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic [31:0] MulResult,
  output logic        ResultValid,
  output logic        Busy,
  output logic        Stall,
  output logic [1:0]  dbg_state
);
  localparam int N = 32 / RADIX_BITS;

  localparam logic [4:0] OP_MULT  = 5'b00101;
  localparam logic [4:0] OP_MULTU = 5'b01110;
  localparam logic [4:0] OP_MADD  = 5'b01100;
  localparam logic [4:0] OP_MSUB  = 5'b01101;
  localparam logic [4:0] OP_MUL   = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10000;
  localparam logic [4:0] OP_MFLO  = 5'b10010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic [63:0] a_q, a_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mul_result_q, mul_result_d;

  logic        is_mulop, is_mt, is_mf, is_signed;
  logic [31:0] a_mag, b_mag;
  logic [63:0] partial, sum, product;

  always_comb begin
    is_mulop  = HiLoWrite && (ALUCtl inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MUL});
    is_mt     = HiLoWrite && (ALUCtl == OP_MTHI || ALUCtl == OP_MTLO);
    is_mf     = !HiLoWrite && (ALUCtl == OP_MFHI || ALUCtl == OP_MFLO);
    is_signed = (ALUCtl != OP_MULTU);
    a_mag     = (is_signed && A[31]) ? (~A + 32'd1) : A;
    b_mag     = (is_signed && B[31]) ? (~B + 32'd1) : B;

    // One shift-add step; product is only meaningful on the final step.
    partial = a_q * {{(64-RADIX_BITS){1'b0}}, b_q[RADIX_BITS-1:0]};
    sum     = acc_q + partial;
    product = neg_q ? (~sum + 64'd1) : sum;

    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    neg_d        = neg_q;
    a_d          = a_q;
    acc_d        = acc_q;
    b_d          = b_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_result_d = mul_result_q;
    Stall        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (InValid && is_mulop) begin
          a_d     = {32'd0, a_mag};
          b_d     = b_mag;
          acc_d   = 64'd0;
          neg_d   = is_signed && (A[31] ^ B[31]);
          op_d    = ALUCtl;
          cnt_d   = 6'(N);
          state_d = S_MUL;
          Stall   = (ALUCtl == OP_MUL);
        end else if (InValid && is_mt) begin
          if (ALUCtl == OP_MTHI) hi_d = A;
          else                   lo_d = A;
        end
      end
      S_MUL: begin
        // Any HI/LO consumer waits, including the blocking mul itself.
        Stall = InValid && (is_mulop || is_mt || is_mf);
        acc_d = sum;
        a_d   = a_q << RADIX_BITS;
        b_d   = b_q >> RADIX_BITS;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          case (op_q)
            OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + product;
            OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - product;
            OP_MUL:  mul_result_d = product[31:0];
            default: {hi_d, lo_d} = product;
          endcase
          state_d = (op_q == OP_MUL) ? S_DONE : S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 6'd0;
      op_q         <= 5'd0;
      neg_q        <= 1'b0;
      a_q          <= 64'd0;
      acc_q        <= 64'd0;
      b_q          <= 32'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      mul_result_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      a_q          <= a_d;
      acc_q        <= acc_d;
      b_q          <= b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_result_q <= mul_result_d;
    end
  end

  assign HiOut       = hi_q;
  assign LoOut       = lo_q;
  assign MulResult   = mul_result_q;
  assign ResultValid = (state_q == S_DONE);
  assign Busy        = (state_q == S_MUL);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit: vector table of single HI/LO ops plus
// hand sequences for stalls, mul completion, radix-4 timing and async reset.
module tb_hilo_mult_unit;
  localparam logic [4:0] OP_MULT  = 5'b00101;
  localparam logic [4:0] OP_MULTU = 5'b01110;
  localparam logic [4:0] OP_MADD  = 5'b01100;
  localparam logic [4:0] OP_MSUB  = 5'b01101;
  localparam logic [4:0] OP_MUL   = 5'b11000;
  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10011;
  localparam logic [4:0] OP_MFLO  = 5'b10010;
  localparam logic [4:0] OP_ADD   = 5'b00010;

  typedef struct {
    logic [4:0]  op;
    logic        hlw;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  logic        Clk, Rst;
  logic        InValid, HiLoWrite;
  logic [4:0]  ALUCtl;
  logic [31:0] A, B;
  logic [31:0] HiOut, LoOut, MulResult;
  logic        ResultValid, Busy, Stall;
  logic [1:0]  dbg_state;

  logic        v4, hlw4;
  logic [4:0]  op4;
  logic [31:0] a4, b4;
  logic [31:0] hi4, lo4, res4;
  logic        rv4, busy4, stall4;
  logic [1:0]  dbg4;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[16];

  hilo_mult_unit #(.RADIX_BITS(1)) u_dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .ALUCtl(ALUCtl), .HiLoWrite(HiLoWrite),
    .A(A), .B(B), .HiOut(HiOut), .LoOut(LoOut), .MulResult(MulResult),
    .ResultValid(ResultValid), .Busy(Busy), .Stall(Stall), .dbg_state(dbg_state)
  );

  hilo_mult_unit #(.RADIX_BITS(4)) u_dut4 (
    .Clk(Clk), .Rst(Rst), .InValid(v4), .ALUCtl(op4), .HiLoWrite(hlw4),
    .A(a4), .B(b4), .HiOut(hi4), .LoOut(lo4), .MulResult(res4),
    .ResultValid(rv4), .Busy(busy4), .Stall(stall4), .dbg_state(dbg4)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op in IDLE for a single cycle, wait for Busy to drop, check HI/LO.
  task automatic run_op(input vec_t v, input int idx);
    int cycles;
    InValid = 1'b1; ALUCtl = v.op; HiLoWrite = v.hlw; A = v.a; B = v.b;
    #1;
    chk($sformatf("vec%0d_stall", idx), {31'd0, Stall}, 32'd0);
    @(posedge Clk); #1;
    InValid = 1'b0;
    cycles = 0;
    while (Busy && cycles < 200) begin
      cycles++;
      @(posedge Clk); #1;
    end
    chk($sformatf("vec%0d_busy_cycles", idx), 32'(cycles), 32'(v.exp_busy));
    chk($sformatf("vec%0d_hi", idx), HiOut, v.exp_hi);
    chk($sformatf("vec%0d_lo", idx), LoOut, v.exp_lo);
  endtask

  initial begin
    int n;
    vec_t v;
    Rst = 1'b1; InValid = 1'b0; ALUCtl = 5'd0; HiLoWrite = 1'b0; A = 32'd0; B = 32'd0;
    v4 = 1'b0; op4 = 5'd0; hlw4 = 1'b0; a4 = 32'd0; b4 = 32'd0;

    vecs[0]  = '{OP_MULT,  1'b1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 32};
    vecs[1]  = '{OP_MULTU, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 32};
    vecs[2]  = '{OP_MTHI,  1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFE, 0};
    vecs[3]  = '{OP_MTLO,  1'b1, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000005, 0};
    vecs[4]  = '{OP_MADD,  1'b1, 32'h00000003, 32'h00000004, 32'h00000000, 32'h00000011, 32};
    vecs[5]  = '{OP_MSUB,  1'b1, 32'h00000001, 32'h00000012, 32'hFFFFFFFF, 32'hFFFFFFFF, 32};
    vecs[6]  = '{OP_ADD,   1'b0, 32'h0000DEAD, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0};
    vecs[7]  = '{OP_MTHI,  1'b0, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0};
    vecs[8]  = '{OP_MULT,  1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32};
    vecs[9]  = '{OP_MULTU, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32};
    vecs[10] = '{OP_MULT,  1'b1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 32};
    vecs[11] = '{OP_MADD,  1'b1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h0000000F, 32};
    vecs[12] = '{OP_MSUB,  1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000010, 32};
    vecs[13] = '{OP_MULT,  1'b1, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 32};
    vecs[14] = '{OP_MULT,  1'b1, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32};
    vecs[15] = '{OP_MADD,  1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFE, 32'hFFFFFFFA, 32};

    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    #1;
    chk("rst_hi", HiOut, 32'd0);
    chk("rst_lo", LoOut, 32'd0);
    chk("rst_mulresult", MulResult, 32'd0);
    chk("rst_resultvalid", {31'd0, ResultValid}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst4_lo", lo4, 32'd0);

    for (int i = 0; i < 16; i++) run_op(vecs[i], i);

    // mul: blocking, stalls N+1 cycles, one cycle of ResultValid, HI/LO untouched
    InValid = 1'b1; ALUCtl = OP_MUL; HiLoWrite = 1'b1; A = 32'h00000007; B = 32'hFFFFFFFD;
    #1;
    n = 0;
    while (Stall && n < 200) begin
      n++;
      @(posedge Clk); #1;
    end
    chk("mul_stall_cycles", 32'(n), 32'd33);
    chk("mul_resultvalid", {31'd0, ResultValid}, 32'd1);
    chk("mul_state_done", {30'd0, dbg_state}, 32'd2);
    chk("mul_result", MulResult, 32'hFFFFFFEB);
    InValid = 1'b0;
    @(posedge Clk); #1;
    chk("mul_resultvalid_drop", {31'd0, ResultValid}, 32'd0);
    chk("mul_result_hold", MulResult, 32'hFFFFFFEB);
    chk("mul_hi_unchanged", HiOut, 32'h3FFFFFFE);
    chk("mul_lo_unchanged", LoOut, 32'hFFFFFFFA);

    // mult 2x3 then mflo: mflo stalls until the commit
    InValid = 1'b1; ALUCtl = OP_MULT; HiLoWrite = 1'b1; A = 32'd2; B = 32'd3;
    #1 chk("mult_accept_stall", {31'd0, Stall}, 32'd0);
    @(posedge Clk); #1;
    ALUCtl = OP_MFLO; HiLoWrite = 1'b0;
    #1;
    n = 0;
    while (Stall && n < 200) begin
      n++;
      @(posedge Clk); #1;
    end
    chk("mflo_stall_cycles", 32'(n), 32'd32);
    chk("mflo_lo", LoOut, 32'h00000006);
    chk("mflo_hi", HiOut, 32'h00000000);
    InValid = 1'b0;

    // mult 5x5, a non-HI/LO op during MUL, then mthi which must win after commit
    @(posedge Clk); #1;
    InValid = 1'b1; ALUCtl = OP_MULT; HiLoWrite = 1'b1; A = 32'd5; B = 32'd5;
    @(posedge Clk); #1;
    ALUCtl = OP_ADD; HiLoWrite = 1'b0;
    #1 chk("nonhilo_no_stall", {31'd0, Stall}, 32'd0);
    @(posedge Clk); #1;
    ALUCtl = OP_MTHI; HiLoWrite = 1'b1; A = 32'h0000ABCD;
    #1;
    n = 0;
    while (Stall && n < 200) begin
      n++;
      @(posedge Clk); #1;
    end
    chk("mthi_stall_cycles", 32'(n), 32'd31);
    chk("mthi_blocked_hi", HiOut, 32'h00000000);
    chk("mthi_commit_lo", LoOut, 32'h00000019);
    @(posedge Clk); #1;
    InValid = 1'b0;
    chk("mthi_after_hi", HiOut, 32'h0000ABCD);
    chk("mthi_after_lo", LoOut, 32'h00000019);

    // radix-4 instance: 8-cycle multiply, mflo stalls 8 cycles
    v4 = 1'b1; op4 = OP_MULT; hlw4 = 1'b1; a4 = 32'd2; b4 = 32'd3;
    @(posedge Clk); #1;
    chk("r4_busy", {31'd0, busy4}, 32'd1);
    op4 = OP_MFLO; hlw4 = 1'b0;
    #1;
    n = 0;
    while (stall4 && n < 200) begin
      n++;
      @(posedge Clk); #1;
    end
    chk("r4_mflo_stall_cycles", 32'(n), 32'd8);
    chk("r4_lo", lo4, 32'h00000006);
    v4 = 1'b0;

    // async reset in the middle of a multiply
    InValid = 1'b1; ALUCtl = OP_MULT; HiLoWrite = 1'b1; A = 32'h00001234; B = 32'h00005678;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    InValid = 1'b1; ALUCtl = OP_MFLO; HiLoWrite = 1'b0;
    #1 chk("pre_rst_stall", {31'd0, Stall}, 32'd1);
    Rst = 1'b1;
    #1;
    chk("arst_hi", HiOut, 32'd0);
    chk("arst_lo", LoOut, 32'd0);
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_stall", {31'd0, Stall}, 32'd0);
    chk("arst_mulresult", MulResult, 32'd0);
    chk("arst_state", {30'd0, dbg_state}, 32'd0);
    InValid = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    v = '{OP_MULT, 1'b1, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 32};
    run_op(v, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
